// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (CPU vs audio DMA).
package mem_arb_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_DMA  = 2'd2
    } rd_owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter: counts consecutive cycles the DMA lost arbitration.
module arb_wait_counter
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  clr,
    input  logic [WAIT_CNT_W-1:0] limit,
    output logic                  at_limit
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data memory arbiter: CPU priority with DMA starvation guard and 1-cycle read return.
// Define ARB_PERF_CNT_EN to add saturating stall/grant performance counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DMA_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
`ifdef ARB_PERF_CNT_EN
    input  logic              perf_clr,
    output logic [15:0]       perf_cpu_stall_cnt,
    output logic [15:0]       perf_dma_gnt_cnt,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_CNT_W-1:0] MaxWait = WAIT_CNT_W'(DMA_MAX_WAIT);

    logic      at_limit;
    logic      cpu_gnt;
    rd_owner_t rd_owner_q, rd_owner_d;

    arb_wait_counter u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (dma_req & ~dma_gnt),
        .clr      (dma_gnt | ~dma_req),
        .limit    (MaxWait),
        .at_limit (at_limit)
    );

    // Grants are suppressed in reset; stall keeps its raw form so it stays 0 there too.
    always_comb begin
        cpu_gnt   = ~reset & cpu_req & ~(dma_req & at_limit);
        dma_gnt   = ~reset & dma_req & ~cpu_gnt;
        cpu_stall = cpu_req & dma_req & at_limit;
        mem_en    = cpu_gnt | dma_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    always_comb begin
        rd_owner_d = RD_NONE;
        if (cpu_gnt && !cpu_we) begin
            rd_owner_d = RD_CPU;
        end else if (dma_gnt && !dma_we) begin
            rd_owner_d = RD_DMA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_q <= RD_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        cpu_rvalid = (rd_owner_q == RD_CPU);
        dma_rvalid = (rd_owner_q == RD_DMA);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dma_rdata  = dma_rvalid ? mem_rdata : '0;
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] gnt_cnt_q, gnt_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        gnt_cnt_d   = gnt_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            gnt_cnt_d   = '0;
        end else begin
            if (cpu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
            if (dma_gnt && (gnt_cnt_q != 16'hFFFF))     gnt_cnt_d   = gnt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            gnt_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            gnt_cnt_q   <= gnt_cnt_d;
        end
    end

    assign perf_cpu_stall_cnt = stall_cnt_q;
    assign perf_dma_gnt_cnt   = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic vs a reference model.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned DMA_MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic              perf_clr;
    logic [15:0]       perf_cpu_stall_cnt, perf_dma_gnt_cnt;
    int                m_stall_cnt, m_gnt_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          lost;          // consecutive cycles the DMA has been refused
    int          pend;          // 0 none, 1 CPU read return due, 2 DMA read return due
    logic [31:0] pend_data;
    logic [31:0] smem [256];
    logic        last_dma_gnt;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .DMA_MAX_WAIT (DMA_MAX_WAIT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_req            (cpu_req),
        .cpu_we             (cpu_we),
        .cpu_addr           (cpu_addr),
        .cpu_wdata          (cpu_wdata),
        .cpu_stall          (cpu_stall),
        .cpu_rvalid         (cpu_rvalid),
        .cpu_rdata          (cpu_rdata),
        .dma_req            (dma_req),
        .dma_we             (dma_we),
        .dma_addr           (dma_addr),
        .dma_wdata          (dma_wdata),
        .dma_gnt            (dma_gnt),
        .dma_rvalid         (dma_rvalid),
        .dma_rdata          (dma_rdata),
`ifdef ARB_PERF_CNT_EN
        .perf_clr           (perf_clr),
        .perf_cpu_stall_cnt (perf_cpu_stall_cnt),
        .perf_dma_gnt_cnt   (perf_dma_gnt_cnt),
`endif
        .mem_en             (mem_en),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata)
    );

    // Synchronous single-port RAM, 1-cycle read latency, cleared by reset
    logic [31:0] ram [256];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        lost         = 0;
        pend         = 0;
        pend_data    = '0;
        last_dma_gnt = 1'b0;
        for (int i = 0; i < 256; i++) smem[i] = '0;
`ifdef ARB_PERF_CNT_EN
        m_stall_cnt = 0;
        m_gnt_cnt   = 0;
`endif
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one clock.
    task automatic run_cycle();
        logic        e_cg, e_dg, e_we;
        logic [31:0] e_addr, e_wdata;
        #1;
        e_cg    = cpu_req && !(dma_req && lost == DMA_MAX_WAIT);
        e_dg    = dma_req && !e_cg;
        e_we    = e_cg ? cpu_we    : (e_dg ? dma_we    : 1'b0);
        e_addr  = e_cg ? cpu_addr  : (e_dg ? dma_addr  : 32'd0);
        e_wdata = e_cg ? cpu_wdata : (e_dg ? dma_wdata : 32'd0);
        check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cg));
        check("dma_gnt", 32'(dma_gnt), 32'(e_dg));
        check("mem_en", 32'(mem_en), 32'(e_cg || e_dg));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(pend == 1));
        check("dma_rvalid", 32'(dma_rvalid), 32'(pend == 2));
        if (pend == 1) check("cpu_rdata", cpu_rdata, pend_data);
        if (pend == 2) check("dma_rdata", dma_rdata, pend_data);
`ifdef ARB_PERF_CNT_EN
        check("perf_stall", 32'(perf_cpu_stall_cnt), 32'(m_stall_cnt));
        check("perf_gnt", 32'(perf_dma_gnt_cnt), 32'(m_gnt_cnt));
`endif
        @(posedge clk);
        pend = 0;
        if (e_cg || e_dg) begin
            if (e_we) smem[e_addr[7:0]] = e_wdata;
            else begin
                pend      = e_cg ? 1 : 2;
                pend_data = smem[e_addr[7:0]];
            end
        end
        if (dma_req && !e_dg) lost = (lost < DMA_MAX_WAIT) ? lost + 1 : DMA_MAX_WAIT;
        else                  lost = 0;
`ifdef ARB_PERF_CNT_EN
        if (perf_clr) begin
            m_stall_cnt = 0;
            m_gnt_cnt   = 0;
        end else begin
            if (cpu_req && !e_cg && m_stall_cnt < 65535) m_stall_cnt++;
            if (e_dg && m_gnt_cnt < 65535)               m_gnt_cnt++;
        end
`endif
        last_dma_gnt = e_dg;
        @(negedge clk);
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
        run_cycle();
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
`ifdef ARB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; dma_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Sustained contention: CPU wins four, DMA takes the fifth, twice over
        for (int i = 0; i < 10; i++) drive(1, 0, 32'h10, 0, 1, 0, 32'h40, 0);
`ifdef ARB_PERF_CNT_EN
        #1;
        check("perf_stall_10", 32'(perf_cpu_stall_cnt), 32'd2);
        check("perf_gnt_10", 32'(perf_dma_gnt_cnt), 32'd2);
        perf_clr = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        perf_clr = 1'b0;
        #1;
        check("perf_clr_stall", 32'(perf_cpu_stall_cnt), 32'd0);
        check("perf_clr_gnt", 32'(perf_dma_gnt_cnt), 32'd0);
        @(negedge clk);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h10, 32'hCAFE0001, 0, 0, 0, 0);
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h20, 32'hA5A50020, 0, 0, 0, 0);
        drive(1, 1, 32'h24, 32'h5A5A0024, 0, 0, 0, 0);
        drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 32'h24, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 32'h30, 32'h1234);
        drive(1, 0, 32'h30, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while a read return is pending drops it
        drive(1, 0, 32'h30, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check("rst_drop_rvalid", 32'(cpu_rvalid), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; DMA holds its request stable until granted
        dma_req = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cpu_req   = ($urandom_range(0, 9) < 6);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 32'($urandom_range(0, 255));
            cpu_wdata = $urandom();
            if (!(dma_req && !last_dma_gnt)) begin
                dma_req   = 1'($urandom_range(0, 1));
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = 32'($urandom_range(0, 255));
                dma_wdata = $urandom();
            end
`ifdef ARB_PERF_CNT_EN
            perf_clr = ($urandom_range(0, 19) == 0);
`endif
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port data memory between the pipeline's Memory stage (CPU port) and the audio sample DMA engine that streams FIR input/output samples.
- Decides the grant every cycle, stalls the CPU port when it loses, and routes synchronous-RAM read data (1-cycle latency) back to whichever requester issued the read.
- CPU has priority by default; a starvation counter guarantees DMA progress.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, data width
- DMA_MAX_WAIT, 4, consecutive DMA-lost cycles before DMA is forced to win; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cpu_req  in  1  CPU memory access this cycle
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  CPU request not granted this cycle; pipeline holds M stage
- cpu_rvalid  out  1  cpu_rdata valid (cycle after granted CPU read)
- cpu_rdata  out  DATA_W  CPU read data
- dma_req  in  1  DMA access request; held with fields stable until dma_gnt
- dma_we  in  1  DMA write/read
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  DATA_W  DMA read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read

Behaviour:
- Grant (combinational, same cycle): with only one requester, it wins. With both requesting, DMA wins iff wait_cnt == DMA_MAX_WAIT; otherwise CPU wins.
- cpu_stall = cpu_req & ~cpu_gnt. dma_gnt = dma_req & ~cpu_gnt.
- Memory mux: mem_en = cpu_gnt | dma_gnt. mem_we and mem_addr come from the winner. When there is no winner, mem_we = 0 and mem_addr/mem_wdata = 0.
- wait_cnt (4-bit register):
  - Reset to 0.
  - Incremented when dma_req & ~dma_gnt, saturating at DMA_MAX_WAIT.
  - Cleared on dma_gnt, or when dma_req is low.
- Read-return FSM (rd_owner register), states RD_NONE, RD_CPU, RD_DMA:
  - Next state is RD_CPU after a granted CPU read, RD_DMA after a granted DMA read, and RD_NONE otherwise (writes and idle cycles).
  - Every state can go to any state each cycle; back-to-back reads pipeline fully.
- Return outputs: cpu_rvalid = (rd_owner == RD_CPU) and dma_rvalid = (rd_owner == RD_DMA). Both rdata outputs are driven from mem_rdata, and each is valid only with its own rvalid.
- Reset values: rd_owner = RD_NONE and wait_cnt = 0. All outputs are 0 during reset except cpu_stall, which is cpu_req & dma_req & forced-DMA condition. That term evaluates to 0, so cpu_stall is effectively 0.
- Reset mid-read: the pending return is dropped and no rvalid pulse is produced.
- Simultaneous write and read to the same address from different requesters cannot occur in one cycle (single grant). Ordering is grant order.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_cpu_stall_cnt (16) and perf_dma_gnt_cnt (16).
  - Both are saturating counters, cleared by reset, and incremented on cpu_stall and dma_gnt respectively.
  - perf_clr input (1) clears both synchronously. If perf_clr and an increment coincide, clear wins.
- Not defined: the ports and counters are absent and arbitration behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] rd_owner_t {RD_NONE, RD_CPU, RD_DMA}
  - WAIT_CNT_W = 4
- Sub-module arb_wait_counter holds the saturating starvation counter. Inputs: inc, clr, limit. Output: at_limit.

Test Plan:
- reset high with cpu_req=1 and dma_req=1 → mem_en=0, cpu_rvalid=0, dma_rvalid=0; after release, first cycle CPU wins.
- CPU read addr 0x10 (mem holds 0xCAFE0001), dma_req=0 → mem_en=1 and cpu_stall=0 in cycle N; cycle N+1 cpu_rvalid=1 with cpu_rdata=0xCAFE0001, and dma_rvalid=0.
- cpu_req and dma_req held high continuously, DMA_MAX_WAIT=4 → CPU wins 4 cycles. On the 5th, dma_gnt=1 and cpu_stall=1. Pattern repeats every 5 cycles.
- Back-to-back reads: CPU read 0x20 then DMA read 0x24 on consecutive cycles → cpu_rvalid next cycle, then dma_rvalid the cycle after, each with correct data.
- DMA write 0x30 = 0x1234 while cpu_req=0 → dma_gnt=1, mem_we=1, mem_addr=0x30. CPU reads 0x30 next cycle → returns 0x1234.
- With ARB_PERF_CNT_EN: 10-cycle contention at DMA_MAX_WAIT=4 → perf_cpu_stall_cnt=2, perf_dma_gnt_cnt=2. perf_clr → both 0 next cycle.
